alu_issue_stage: RTL and testbench

//  Decode/issue stage that drives the ALU: accepts a RISC-V RV32IM instruction with PC and register values.

---
 rtl/alu_issue_stage_pkg.sv | 60 ++++++
 rtl/alu_issue_stage_imm_gen.sv | 21 ++
 rtl/alu_issue_stage.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: ALU opcodes, RV32 major opcodes,
// pipe states and funct3-to-opcode helpers.
package alu_issue_stage_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000, ALU_SLL  = 5'b00001, ALU_SLT  = 5'b00010, ALU_SLTU = 5'b00011,
        ALU_XOR  = 5'b00100, ALU_SRL  = 5'b00101, ALU_SRA  = 5'b10101, ALU_OR   = 5'b00110,
        ALU_AND  = 5'b00111, ALU_SUB  = 5'b10000, ALU_MUL  = 5'b11000, ALU_DIV  = 5'b11100,
        ALU_LUI  = 5'b11110, ALU_FWD  = 5'b10001, ALU_BEQ  = 5'b01000, ALU_BNE  = 5'b01001,
        ALU_BLT  = 5'b01100, ALU_BGE  = 5'b01101, ALU_BLTU = 5'b01110, ALU_BGEU = 5'b01111
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} pipe_state_e;

    // Base-ISA register/immediate op selected by funct3 (funct7 = 0000000 flavour).
    function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch compare op; 010/011 are reserved and reported through valid=0.
    function automatic logic [5:0] branch_alu_op(input logic [2:0] funct3);
        logic [5:0] res;
        case (funct3)
            3'b000:  res = {1'b1, ALU_BEQ};
            3'b001:  res = {1'b1, ALU_BNE};
            3'b100:  res = {1'b1, ALU_BLT};
            3'b101:  res = {1'b1, ALU_BGE};
            3'b110:  res = {1'b1, ALU_BLTU};
            3'b111:  res = {1'b1, ALU_BGEU};
            default: res = {1'b0, ALU_ADD};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_issue_stage_imm_gen.sv
// Combinational RV32 immediate extraction with sign extension to XLEN.
module alu_issue_stage_imm_gen
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

endmodule

// File: rtl/alu_issue_stage.sv
// RV32IM decode/issue stage: decodes one instruction into an ALU entry and
// issues it through a registered main+skid pipe.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_alu_opcode,
    output logic [XLEN-1:0] out_operand_a,
    output logic [XLEN-1:0] out_operand_b,
    output logic [XLEN-1:0] out_branch_target,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_is_branch,
    output logic            out_illegal
);

    typedef struct packed {
        logic [4:0]      alu_opcode;
        logic [XLEN-1:0] operand_a;
        logic [XLEN-1:0] operand_b;
        logic [XLEN-1:0] branch_target;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            is_branch;
        logic            illegal;
    } entry_t;

    localparam logic [XLEN-1:0] LINK_OFFSET = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [6:0]      opcode_s, funct7_s;
    logic [2:0]      funct3_s;
    logic [5:0]      br_sel_s;
    logic            wr_req_s, ill_s;
    entry_t          dec_s, rst_entry_s;
    entry_t          main_r, skid_r;
    pipe_state_e     state_r;
    logic            out_valid_r, in_ready_r;
    logic            push_s, pop_s;

    alu_issue_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .imm_i (imm_i_s),
        .imm_s (imm_s_s),
        .imm_b (imm_b_s),
        .imm_u (imm_u_s),
        .imm_j (imm_j_s)
    );

    assign opcode_s   = in_instr[6:0];
    assign funct3_s   = in_instr[14:12];
    assign funct7_s   = in_instr[31:25];
    assign jalr_sum_s = in_rs1_val + imm_i_s;
    assign br_sel_s   = branch_alu_op(funct3_s);

    // Decode the incoming instruction into a complete issue entry.
    always_comb begin
        dec_s            = '0;
        wr_req_s         = 1'b0;
        ill_s            = 1'b0;
        dec_s.alu_opcode = ALU_ADD;
        dec_s.operand_a  = in_rs1_val;
        dec_s.operand_b  = in_rs2_val;
        case (opcode_s)
            OPC_OP: begin
                wr_req_s = 1'b1;
                case (funct7_s)
                    F7_BASE: dec_s.alu_opcode = base_alu_op(funct3_s);
                    F7_ALT: begin
                        if (funct3_s == 3'b000) begin
                            dec_s.alu_opcode = ALU_SUB;
                        end else if (funct3_s == 3'b101) begin
                            dec_s.alu_opcode = ALU_SRA;
                        end else begin
                            ill_s = 1'b1;
                        end
                    end
                    F7_MULDIV: begin
                        if (funct3_s == 3'b000) begin
                            dec_s.alu_opcode = ALU_MUL;
                        end else if (funct3_s == 3'b100) begin
                            dec_s.alu_opcode = ALU_DIV;
                        end else begin
                            ill_s = 1'b1;
                        end
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                wr_req_s         = 1'b1;
                dec_s.alu_opcode = base_alu_op(funct3_s);
                dec_s.operand_b  = imm_i_s;
                // Shift-immediates take a zero-extended shamt and constrain funct7.
                if (funct3_s == 3'b001 || funct3_s == 3'b101) begin
                    dec_s.operand_b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                    if (funct7_s == F7_ALT && funct3_s == 3'b101) begin
                        dec_s.alu_opcode = ALU_SRA;
                    end else if (funct7_s != F7_BASE) begin
                        ill_s = 1'b1;
                    end else begin
                        ill_s = 1'b0;
                    end
                end else begin
                    ill_s = 1'b0;
                end
            end
            OPC_LUI: begin
                wr_req_s         = 1'b1;
                dec_s.alu_opcode = ALU_LUI;
                dec_s.operand_a  = {XLEN{1'b0}};
                dec_s.operand_b  = imm_u_s;
            end
            OPC_AUIPC: begin
                wr_req_s        = 1'b1;
                dec_s.operand_a = in_pc;
                dec_s.operand_b = imm_u_s;
            end
            OPC_LOAD: begin
                wr_req_s        = 1'b1;
                dec_s.mem_read  = 1'b1;
                dec_s.operand_b = imm_i_s;
                ill_s = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111);
            end
            OPC_STORE: begin
                dec_s.mem_write  = 1'b1;
                dec_s.operand_b  = imm_s_s;
                dec_s.store_data = in_rs2_val;
                ill_s = funct3_s[2] || (funct3_s == 3'b011);
            end
            OPC_BRANCH: begin
                dec_s.alu_opcode    = br_sel_s[4:0];
                dec_s.is_branch     = 1'b1;
                dec_s.branch_target = in_pc + imm_b_s;
                ill_s = !br_sel_s[5];
            end
            OPC_JAL: begin
                wr_req_s            = 1'b1;
                dec_s.alu_opcode    = ALU_FWD;
                dec_s.operand_a     = in_pc;
                dec_s.operand_b     = LINK_OFFSET;
                dec_s.is_branch     = 1'b1;
                dec_s.branch_target = in_pc + imm_j_s;
            end
            OPC_JALR: begin
                wr_req_s            = 1'b1;
                dec_s.alu_opcode    = ALU_FWD;
                dec_s.operand_a     = in_pc;
                dec_s.operand_b     = LINK_OFFSET;
                dec_s.is_branch     = 1'b1;
                dec_s.branch_target = {jalr_sum_s[XLEN-1:1], 1'b0};
                ill_s = (funct3_s != 3'b000);
            end
            default: ill_s = 1'b1;
        endcase
        // An illegal encoding carries no side effects; writes to x0 are dropped.
        if (ill_s) begin
            dec_s         = '0;
            dec_s.illegal = 1'b1;
        end else if (wr_req_s && (in_instr[11:7] != 5'd0)) begin
            dec_s.rd        = in_instr[11:7];
            dec_s.reg_write = 1'b1;
        end else begin
            dec_s.rd        = 5'd0;
            dec_s.reg_write = 1'b0;
        end
    end

    // Value loaded into the entry registers on reset or flush.
    always_comb begin
        rst_entry_s               = '0;
        rst_entry_s.branch_target = RESET_PC;
    end

    assign push_s = in_valid && in_ready_r;
    assign pop_s  = out_valid_r && out_ready;

    // Main/skid pipe control: EMPTY -> ONE -> TWO, with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_r     <= ST_EMPTY;
            main_r      <= rst_entry_s;
            skid_r      <= rst_entry_s;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        main_r      <= dec_s;
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_ONE: begin
                    case ({push_s, pop_s})
                        2'b10: begin
                            skid_r     <= dec_s;
                            state_r    <= ST_TWO;
                            in_ready_r <= 1'b0;
                        end
                        2'b01: begin
                            state_r     <= ST_EMPTY;
                            out_valid_r <= 1'b0;
                        end
                        2'b11:   main_r <= dec_s;
                        default: state_r <= ST_ONE;
                    endcase
                end
                ST_TWO: begin
                    if (pop_s) begin
                        main_r     <= skid_r;
                        state_r    <= ST_ONE;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_TWO;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready          = in_ready_r;
    assign out_valid         = out_valid_r;
    assign out_alu_opcode    = main_r.alu_opcode;
    assign out_operand_a     = main_r.operand_a;
    assign out_operand_b     = main_r.operand_b;
    assign out_branch_target = main_r.branch_target;
    assign out_store_data    = main_r.store_data;
    assign out_rd            = main_r.rd;
    assign out_reg_write     = main_r.reg_write;
    assign out_mem_read      = main_r.mem_read;
    assign out_mem_write     = main_r.mem_write;
    assign out_is_branch     = main_r.is_branch;
    assign out_illegal       = main_r.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode vectors, stall/skid,
// flush and reset behaviour, with hand-computed expectations.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val;
    logic [4:0]  out_alu_opcode, out_rd;
    logic [31:0] out_operand_a, out_operand_b, out_branch_target, out_store_data;
    logic        out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_illegal;
    int          checks = 0;
    int          failures = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_ADDX0 = 32'h00208033;
    localparam logic [31:0] I_BEQ   = 32'h00208863;
    localparam logic [31:0] I_JALR  = 32'h008280E7;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_ADDI  = 32'hFFF00293;
    localparam logic [31:0] I_SW    = 32'h0020A623;
    localparam logic [31:0] I_LUI   = 32'h123453B7;
    localparam logic [31:0] I_SRAI  = 32'h4030D213;
    localparam logic [31:0] I_BAD   = 32'h0000007F;
    localparam logic [31:0] I_MULH  = 32'h022091B3;

    alu_issue_stage dut (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready), .in_instr (in_instr), .in_pc (in_pc),
        .in_rs1_val (in_rs1_val), .in_rs2_val (in_rs2_val),
        .out_valid (out_valid), .out_ready (out_ready), .out_alu_opcode (out_alu_opcode),
        .out_operand_a (out_operand_a), .out_operand_b (out_operand_b),
        .out_branch_target (out_branch_target), .out_store_data (out_store_data),
        .out_rd (out_rd), .out_reg_write (out_reg_write), .out_mem_read (out_mem_read),
        .out_mem_write (out_mem_write), .out_is_branch (out_is_branch), .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_entry(input string tag, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] tgt, input logic [31:0] sd,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic mw, input logic br, input logic ill);
        check({tag, ".valid"},  {31'd0, out_valid}, 32'd1);
        check({tag, ".op"},     {27'd0, out_alu_opcode}, {27'd0, op});
        check({tag, ".a"},      out_operand_a, a);
        check({tag, ".b"},      out_operand_b, b);
        check({tag, ".target"}, out_branch_target, tgt);
        check({tag, ".sdata"},  out_store_data, sd);
        check({tag, ".rd"},     {27'd0, out_rd}, {27'd0, rd});
        check({tag, ".ctl"},    {27'd0, out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_illegal},
                                {27'd0, rw, mr, mw, br, ill});
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_pc      = pc;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; in_pc = 32'd0; in_rs1_val = 32'd0; in_rs2_val = 32'd0;
        repeat (2) @(negedge clk);
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.ready", {31'd0, in_ready}, 32'd1);
        check("rst.a", out_operand_a, 32'd0);
        rst_n = 1'b1;

        // Single-issue decode vectors, one-cycle latency each.
        @(negedge clk); drive(I_ADD, 32'h0, 32'd5, 32'd7);
        @(negedge clk); in_valid = 1'b0;
        check_entry("add", 5'b00000, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); check("idle.valid", {31'd0, out_valid}, 32'd0);
        drive(I_BEQ, 32'h100, 32'h11, 32'h22);
        @(negedge clk); in_valid = 1'b0;
        check_entry("beq", 5'b01000, 32'h11, 32'h22, 32'h110, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(I_JALR, 32'h200, 32'h203, 32'h55);
        @(negedge clk); in_valid = 1'b0;
        check_entry("jalr", 5'b10001, 32'h200, 32'd4, 32'h20A, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(I_JAL, 32'h300, 32'h1, 32'h2);
        @(negedge clk); in_valid = 1'b0;
        check_entry("jal", 5'b10001, 32'h300, 32'd4, 32'h308, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(I_ADDI, 32'h0, 32'd10, 32'd3);
        @(negedge clk); in_valid = 1'b0;
        check_entry("addi", 5'b00000, 32'd10, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(I_SW, 32'h0, 32'h1000, 32'hDEADBEEF);
        @(negedge clk); in_valid = 1'b0;
        check_entry("sw", 5'b00000, 32'h1000, 32'd12, 32'd0, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(I_LUI, 32'h40, 32'h99, 32'h98);
        @(negedge clk); in_valid = 1'b0;
        check_entry("lui", 5'b11110, 32'd0, 32'h12345000, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(I_SRAI, 32'h0, 32'h80000000, 32'h7);
        @(negedge clk); in_valid = 1'b0;
        check_entry("srai", 5'b10101, 32'h80000000, 32'd3, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(I_ADDX0, 32'h0, 32'd1, 32'd2);
        @(negedge clk); in_valid = 1'b0;
        check_entry("add_x0", 5'b00000, 32'd1, 32'd2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(I_BAD, 32'h44, 32'h33, 32'h22);
        @(negedge clk); in_valid = 1'b0;
        check_entry("illegal", 5'b00000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(I_MULH, 32'h48, 32'h33, 32'h22);
        @(negedge clk); in_valid = 1'b0;
        check_entry("mulh", 5'b00000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Stall: three requests against a blocked consumer, then release.
        @(negedge clk); out_ready = 1'b0; drive(I_ADD, 32'h0, 32'hA1, 32'd0);
        @(negedge clk);
        check("stall1.valid", {31'd0, out_valid}, 32'd1);
        check("stall1.ready", {31'd0, in_ready}, 32'd1);
        check("stall1.a", out_operand_a, 32'hA1);
        drive(I_ADD, 32'h0, 32'hA2, 32'd0);
        @(negedge clk);
        check("stall2.ready", {31'd0, in_ready}, 32'd0);
        check("stall2.a", out_operand_a, 32'hA1);
        drive(I_ADD, 32'h0, 32'hA3, 32'd0);
        @(negedge clk);
        check("stall3.ready", {31'd0, in_ready}, 32'd0);
        check("stall3.a", out_operand_a, 32'hA1);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain1.a", out_operand_a, 32'hA2);
        check("drain1.ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("drain2.valid", {31'd0, out_valid}, 32'd1);
        check("drain2.a", out_operand_a, 32'hA3);
        in_valid = 1'b0;
        @(negedge clk);
        check("drain3.valid", {31'd0, out_valid}, 32'd0);

        // Flush with both entries held; flush-cycle input must be dropped.
        out_ready = 1'b0; drive(I_ADD, 32'h0, 32'hD1, 32'd0);
        @(negedge clk); drive(I_ADD, 32'h0, 32'hD2, 32'd0);
        @(negedge clk);
        check("preflush.ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; drive(I_ADD, 32'h0, 32'hF1, 32'd0);
        @(negedge clk);
        check("flush.valid", {31'd0, out_valid}, 32'd0);
        check("flush.ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("postflush.valid", {31'd0, out_valid}, 32'd0);
        drive(I_ADD, 32'h0, 32'h61, 32'd0);
        @(negedge clk); in_valid = 1'b0;
        check("postflush.a", out_operand_a, 32'h61);
        check("postflush.valid2", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        check("postflush.idle", {31'd0, out_valid}, 32'd0);

        // Reset during a full stall clears everything.
        out_ready = 1'b0; drive(I_BEQ, 32'h100, 32'h11, 32'h22);
        @(negedge clk);
        @(negedge clk);
        check("prerst.ready", {31'd0, in_ready}, 32'd0);
        check("prerst.target", out_branch_target, 32'h110);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("midrst.valid", {31'd0, out_valid}, 32'd0);
        check("midrst.ready", {31'd0, in_ready}, 32'd1);
        check("midrst.op", {27'd0, out_alu_opcode}, 32'd0);
        check("midrst.a", out_operand_a, 32'd0);
        check("midrst.b", out_operand_b, 32'd0);
        check("midrst.target", out_branch_target, 32'd0);
        check("midrst.ctl", {26'd0, out_rd, out_is_branch}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
